// File: rtl/regfile_wb_sched_if.sv
//==============================================================================
// regfile_wb_sched_if : write-back request/grant bundle between the sequencer
//                       and the register-file write-back scheduler.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface regfile_wb_sched_if;
  logic [2:0] req;
  logic [8:0] dst;
  logic [2:0] pair;
  logic [2:0] ack;
  logic       err;
  logic       busy;
  logic [1:0] gnt_id;
  logic [2:0] src_oh;
  logic [6:0] ld;

  modport master (
    output req, dst, pair,
    input  ack, err, busy, gnt_id, src_oh, ld
  );

  modport slave (
    input  req, dst, pair,
    output ack, err, busy, gnt_id, src_oh, ld
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
//==============================================================================
// regfile_wb_sched : arbitrates ALU / MEM / IDU write-backs into A,L,H,E,D,C,B
//                    as source-drive, load-pulse, hold. Optional macro
//                    REGWB_RR_EN selects round-robin instead of fixed priority.
// Revision: 1.0
//==============================================================================
`default_nettype none

module regfile_wb_sched (
  input  logic                  CLK,
  input  logic                  nRES,
  regfile_wb_sched_if.slave     wb
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_gnt;
  logic [2:0] r_dst;
  logic       r_pair;

  logic [2:0] w_mask;
  logic [2:0] w_reqm;
  logic [1:0] w_start;
  logic [1:0] w_win;
  logic       w_win_vld;
  logic [2:0] w_win_dst;
  logic       w_win_pair;
  logic       w_win_bad;
  logic       w_arb;
  logic [2:0] w_gnt_oh;
  logic [2:0] w_src;
  logic [6:0] w_ld_dec;

  assign w_arb = (r_state == S_IDLE) || (r_state == S_HOLD);

  always_comb begin
    case (r_gnt)
      2'd0:    w_gnt_oh = 3'b001;
      2'd1:    w_gnt_oh = 3'b010;
      2'd2:    w_gnt_oh = 3'b100;
      default: w_gnt_oh = 3'b000;
    endcase
  end

  // The requester just acked in HOLD still shows req this cycle; keep it out.
  assign w_mask = (r_state == S_HOLD) ? w_gnt_oh : 3'b000;
  assign w_reqm = wb.req & ~w_mask;

`ifdef REGWB_RR_EN
  logic [1:0] r_ptr;

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      r_ptr <= 2'd0;
    end else if (w_arb && w_win_vld) begin
      r_ptr <= w_win;
    end
  end

  assign w_start = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
`else
  assign w_start = 2'd0;
`endif

  always_comb begin
    w_win_vld = |w_reqm;
    w_win     = 2'd0;
    case (w_start)
      2'd1: begin
        if (w_reqm[1])      w_win = 2'd1;
        else if (w_reqm[2]) w_win = 2'd2;
        else                w_win = 2'd0;
      end
      2'd2: begin
        if (w_reqm[2])      w_win = 2'd2;
        else if (w_reqm[0]) w_win = 2'd0;
        else                w_win = 2'd1;
      end
      default: begin
        if (w_reqm[0])      w_win = 2'd0;
        else if (w_reqm[1]) w_win = 2'd1;
        else                w_win = 2'd2;
      end
    endcase
  end

  always_comb begin
    case (w_win)
      2'd1: begin
        w_win_dst  = wb.dst[5:3];
        w_win_pair = wb.pair[1];
      end
      2'd2: begin
        w_win_dst  = wb.dst[8:6];
        w_win_pair = wb.pair[2];
      end
      default: begin
        w_win_dst  = wb.dst[2:0];
        w_win_pair = wb.pair[0];
      end
    endcase
  end

  // Pairs are only legal on the high register of H:L, D:E or B:C.
  assign w_win_bad = (w_win_dst == 3'd7) ||
                     (w_win_pair && (w_win_dst != 3'd2) &&
                      (w_win_dst != 3'd4) && (w_win_dst != 3'd6));

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_win_vld) w_next = w_win_bad ? S_ERR : S_SETUP;
        else           w_next = S_IDLE;
      end
      S_SETUP: w_next = S_LOAD;
      S_LOAD:  w_next = S_HOLD;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      r_gnt  <= 2'd3;
      r_dst  <= 3'd0;
      r_pair <= 1'b0;
    end else if (w_arb && w_win_vld) begin
      r_gnt  <= w_win;
      r_dst  <= w_win_dst;
      r_pair <= w_win_pair;
    end else if (w_next == S_IDLE) begin
      r_gnt  <= 2'd3;
    end
  end

  // Fixed source per requester: ALU drives Res, MEM drives Z/W, IDU drives adl/adh.
  always_comb begin
    case (r_gnt)
      2'd0:    w_src = 3'b100;
      2'd1:    w_src = 3'b010;
      2'd2:    w_src = 3'b001;
      default: w_src = 3'b000;
    endcase
  end

  always_comb begin
    case (r_dst)
      3'd0:    w_ld_dec = 7'b0000001;
      3'd1:    w_ld_dec = 7'b0000010;
      3'd2:    w_ld_dec = r_pair ? 7'b0000110 : 7'b0000100;
      3'd3:    w_ld_dec = 7'b0001000;
      3'd4:    w_ld_dec = r_pair ? 7'b0011000 : 7'b0010000;
      3'd5:    w_ld_dec = 7'b0100000;
      3'd6:    w_ld_dec = r_pair ? 7'b1100000 : 7'b1000000;
      default: w_ld_dec = 7'b0000000;
    endcase
  end

  always_comb begin
    wb.ack    = 3'b000;
    wb.err    = 1'b0;
    wb.src_oh = 3'b000;
    wb.ld     = 7'b0000000;
    wb.busy   = (r_state != S_IDLE);
    wb.gnt_id = r_gnt;
    case (r_state)
      S_SETUP: wb.src_oh = w_src;
      S_LOAD: begin
        wb.src_oh = w_src;
        wb.ld     = w_ld_dec;
      end
      S_HOLD: begin
        wb.src_oh = w_src;
        wb.ack    = w_gnt_oh;
      end
      S_ERR: begin
        wb.err = 1'b1;
        wb.ack = w_gnt_oh;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
//==============================================================================
// tb_regfile_wb_sched : directed self-checking bench for regfile_wb_sched.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_regfile_wb_sched;

  logic CLK = 1'b0;
  logic nRES;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_wb_sched_if wb ();

  regfile_wb_sched u_dut (
    .CLK  (CLK),
    .nRES (nRES),
    .wb   (wb)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int got_n;
    int ack_id[3];
    int ack_cyc[3];
    int overlap;
    int exp_id[3];

    nRES    = 1'b0;
    wb.req  = 3'b000;
    wb.dst  = 9'd0;
    wb.pair = 3'b000;
    tick();
    tick();
    check("rst_ld",   32'(wb.ld),     32'h0);
    check("rst_src",  32'(wb.src_oh), 32'h0);
    check("rst_ack",  32'(wb.ack),    32'h0);
    check("rst_err",  32'(wb.err),    32'h0);
    check("rst_busy", 32'(wb.busy),   32'h0);
    check("rst_gnt",  32'(wb.gnt_id), 32'h3);
    nRES = 1'b1;
    tick();

    // Single ALU write to A
    wb.dst  = 9'o000;
    wb.pair = 3'b000;
    wb.req  = 3'b001;
    tick();
    check("alu_setup_src", 32'(wb.src_oh), 32'h4);
    check("alu_setup_ld",  32'(wb.ld),     32'h0);
    check("alu_setup_gnt", 32'(wb.gnt_id), 32'h0);
    check("alu_setup_bsy", 32'(wb.busy),   32'h1);
    tick();
    check("alu_load_src", 32'(wb.src_oh), 32'h4);
    check("alu_load_ld",  32'(wb.ld),     32'h01);
    check("alu_load_ack", 32'(wb.ack),    32'h0);
    tick();
    check("alu_hold_src", 32'(wb.src_oh), 32'h4);
    check("alu_hold_ld",  32'(wb.ld),     32'h0);
    check("alu_hold_ack", 32'(wb.ack),    32'h1);
    wb.req = 3'b000;
    tick();
    check("alu_idle_bsy", 32'(wb.busy),   32'h0);
    check("alu_idle_gnt", 32'(wb.gnt_id), 32'h3);
    check("alu_idle_ack", 32'(wb.ack),    32'h0);

    // MEM pair write to H:L
    wb.dst  = 9'o020;
    wb.pair = 3'b010;
    wb.req  = 3'b010;
    tick();
    check("mem_setup_src", 32'(wb.src_oh), 32'h2);
    check("mem_setup_gnt", 32'(wb.gnt_id), 32'h1);
    tick();
    check("mem_load_ld", 32'(wb.ld), 32'h06);
    tick();
    check("mem_hold_ld",  32'(wb.ld),     32'h0);
    check("mem_hold_ack", 32'(wb.ack),    32'h2);
    check("mem_hold_src", 32'(wb.src_oh), 32'h2);
    wb.req  = 3'b000;
    wb.pair = 3'b000;
    tick();
    check("mem_idle_bsy", 32'(wb.busy), 32'h0);

    // IDU illegal destination code 7
    wb.dst = 9'o700;
    wb.req = 3'b100;
    tick();
    check("ill7_err", 32'(wb.err),    32'h1);
    check("ill7_ack", 32'(wb.ack),    32'h4);
    check("ill7_ld",  32'(wb.ld),     32'h0);
    check("ill7_src", 32'(wb.src_oh), 32'h0);
    wb.req = 3'b000;
    tick();
    check("ill7_idle_err", 32'(wb.err),  32'h0);
    check("ill7_idle_bsy", 32'(wb.busy), 32'h0);

    // IDU illegal pair on E
    wb.dst  = 9'o300;
    wb.pair = 3'b100;
    wb.req  = 3'b100;
    tick();
    check("illp_err", 32'(wb.err), 32'h1);
    check("illp_ack", 32'(wb.ack), 32'h4);
    check("illp_ld",  32'(wb.ld),  32'h0);
    wb.req  = 3'b000;
    wb.pair = 3'b000;
    tick();

    // Contention from a fresh reset so the round-robin pointer starts at 0
    nRES = 1'b0;
    tick();
    nRES = 1'b1;
    wb.dst = 9'o000;
    wb.req = 3'b111;
    got_n   = 0;
    overlap = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((wb.ack != 3'b000) && (wb.ld != 7'b0)) overlap++;
      if (wb.ack != 3'b000) begin
        if (got_n < 3) begin
          ack_id[got_n]  = oh_idx(wb.ack);
          ack_cyc[got_n] = c;
        end
        got_n++;
        wb.req = wb.req & ~wb.ack;
      end
    end
`ifdef REGWB_RR_EN
    exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 0;
`else
    exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 2;
`endif
    check("cont_nacks",   32'(got_n),   32'd3);
    check("cont_overlap", 32'(overlap), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k < got_n) begin
        check($sformatf("cont_id%0d", k),  32'(ack_id[k]),  32'(exp_id[k]));
        check($sformatf("cont_cyc%0d", k), 32'(ack_cyc[k]), 32'(3 * (k + 1)));
      end
    end
    wb.req = 3'b000;
    tick();

`ifdef REGWB_RR_EN
    // Starvation: req[0] held permanently, req[2] must win within two transfers
    begin
      int xfers;
      int seen2;
      xfers = 0;
      seen2 = 0;
      wb.req = 3'b101;
      for (int c = 0; c < 20 && seen2 == 0; c++) begin
        tick();
        if (wb.ack != 3'b000) begin
          xfers++;
          if (wb.ack == 3'b100) begin
            seen2 = 1;
            wb.req = 3'b001;
          end
        end
      end
      check("starve_seen", 32'(seen2), 32'd1);
      check("starve_within2", 32'(xfers <= 2), 32'd1);
      wb.req = 3'b000;
      tick();
      tick();
      tick();
      tick();
    end
`endif

    // Reset during LOAD, then restart of the still-pending request
    wb.dst  = 9'o004;
    wb.pair = 3'b001;
    wb.req  = 3'b001;
    tick();
    check("rl_setup_src", 32'(wb.src_oh), 32'h4);
    tick();
    check("rl_load_ld", 32'(wb.ld), 32'h18);
    nRES = 1'b0;
    tick();
    check("rl_rst_ld",   32'(wb.ld),     32'h0);
    check("rl_rst_busy", 32'(wb.busy),   32'h0);
    check("rl_rst_gnt",  32'(wb.gnt_id), 32'h3);
    check("rl_rst_ack",  32'(wb.ack),    32'h0);
    nRES = 1'b1;
    tick();
    check("rl_re_setup_src", 32'(wb.src_oh), 32'h4);
    check("rl_re_setup_ld",  32'(wb.ld),     32'h0);
    tick();
    check("rl_re_load_ld", 32'(wb.ld), 32'h18);
    tick();
    check("rl_re_hold_ack", 32'(wb.ack), 32'h1);
    check("rl_re_hold_ld",  32'(wb.ld),  32'h0);
    wb.req = 3'b000;
    tick();
    check("rl_re_idle_bsy", 32'(wb.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the general register file (A, L, H, E, D, C, B). It arbitrates between three write-back requesters: ALU result, memory/temp Z:W, and IDU address. It sequences each granted transfer as source-drive, load-pulse and hold, so the falling edge of the register load strobe captures stable data. It sits between the decoder/sequencer and the register-file load and bus-source enables.

## Interface
Parameters: none (requester count fixed at 3).

Ports:
- `CLK` in 1: single clock; all state changes on rising edge.
- `nRES` in 1: synchronous, active-low reset.
- `req[2:0]` in 3: write-back requests.
  - 0 = ALU (Res), 1 = MEM (Z/W), 2 = IDU (adl/adh).
  - Level-held until `ack`.
- `dst[8:0]` in 9: destination code, 3 bits per requester (`dst[3i+2:3i]`).
  - 0 A, 1 L, 2 H, 3 E, 4 D, 5 C, 6 B, 7 invalid.
- `pair[2:0]` in 3: per requester, 1 = 16-bit pair write. Legal only with dst H (H+L), D (D+E) or B (B+C).
- `ack[2:0]` out 3: one-cycle one-hot completion pulse.
- `err` out 1: one-cycle pulse when the granted request is illegal.
- `busy` out 1: high in any state except IDLE.
- `gnt_id[1:0]` out 2: granted requester index. 3 when idle.
- `src_oh[2:0]` out 3: bus source enable to the ebus/fbus mux.
  - bit0 = adl/adh, bit1 = Z/W, bit2 = Res.
- `ld[6:0]` out 7: register load strobes. bit0 A, bit1 L, bit2 H, bit3 E, bit4 D, bit5 C, bit6 B.

## Operation
- States: IDLE, SETUP, LOAD, HOLD, ERR.
- IDLE:
  - If any `req` is set, select a winner by arbitration (see Configuration).
  - Latch the winner's index, `dst` and `pair`.
  - Go to ERR if the code is illegal, else to SETUP.
- Illegal codes: dst = 7, or pair = 1 with dst ∉ {2, 4, 6}.
- SETUP:
  - `src_oh` = one-hot of the requester's fixed source; `gnt_id` valid.
  - Go to LOAD.
- LOAD:
  - `src_oh` is held.
  - `ld` = decoded target: one bit for single, two bits for pair (fbus high byte + ebus low byte).
  - Go to HOLD.
- HOLD:
  - `ld` = 0 (its falling edge is the capture); `src_oh` is held.
  - `ack[gnt_id]` = 1.
  - Re-arbitrate with the acked requester masked. Go to SETUP/ERR if another legal/illegal request is pending, else IDLE.
- ERR:
  - `err` = 1 and `ack[gnt_id]` = 1; `ld` = 0 and `src_oh` = 0.
  - Next state is IDLE.
- Requester obligations:
  - Drop `req`, or present a new `dst`, in the cycle after `ack`.
  - A `req` that falls after the grant does not abort the transfer; it completes and is acked.
- Changes to `dst`/`pair` after the grant are ignored.

## Timing
- Reset (`nRES` = 0 at an edge) takes effect at that edge:
  - State → IDLE.
  - `ld` = 0, `src_oh` = 0, `ack` = 0, `err` = 0, `busy` = 0, `gnt_id` = 3.
  - The arbitration pointer → 0.
- Reset during LOAD drops `ld` immediately. The captured register value is then undefined, and benches do not check it.
- Cycle sequence for a request set while idle: `req` high at edge t is sampled in IDLE; SETUP at t+1, LOAD at t+2, HOLD (with `ack`) at t+3.
- Throughput:
  - Back-to-back legal transfers: one per 3 cycles (HOLD → SETUP).
  - Illegal requests cost 1 cycle after grant (ERR).
- `ld` is high for exactly one cycle per transfer.
- `src_oh` is stable from SETUP through HOLD, covering one cycle before and one cycle after the `ld` pulse.
- Exactly one `ack` bit is high per completed grant. `ack` and `ld` are never high in the same cycle.
- Simultaneous requests: one grant per arbitration. Losers keep waiting, and none are dropped.

## Configuration
- `REGWB_RR_EN` defined: round-robin arbitration.
  - Search starts at (last granted + 1) mod 3. The pointer updates on every grant, including ERR.
- `REGWB_RR_EN` undefined: fixed priority, `req[0]` > `req[1]` > `req[2]`. No pointer state.
- In both modes the HOLD-state mask of the acked requester applies.

## Test plan
- Single ALU write: `req` = 001, dst0 = 0, pair0 = 0.
  - Required: `src_oh` = 100 at t+1..t+3; `ld` = 0000001 at t+2 only; `ack` = 001 at t+3; IDLE at t+4.
- MEM pair write: `req` = 010, dst1 = 2, pair1 = 1.
  - Required: `src_oh` = 010; `ld` = 0000110 for one cycle; `ack` = 010.
- Illegal requests from IDU:
  - dst2 = 7 → `err` = 1 and `ack` = 100 at t+1; `ld` stays 0.
  - pair2 = 1 with dst2 = 3 → same response.
- Contention: `req` = 111 held, each requester dropping `req` after its `ack`.
  - Fixed mode: grants in order 0, 1, 2 with acks at t+3, t+6, t+9.
  - `REGWB_RR_EN` with the pointer after 0: order 1, 2, 0.
- Starvation check (`REGWB_RR_EN` only): `req[0]` held permanently, `req[2]` set.
  - Required: `req[2]` is granted within two transfers.
- Reset mid-LOAD: `nRES` = 0 at the LOAD cycle.
  - Required: next cycle `ld` = 0, `busy` = 0, `gnt_id` = 3, no `ack`.
  - After release, a pending `req` restarts from SETUP with full timing.
